apple1_pia: RTL and testbench

Bus responder emulating the Apple I 6821 PIA keyboard/display registers. Sits on the registered 6502 bus (address, write data, write strobe, enable strobe) as the slave that answers CPU accesses. Bridges CPU reads and writes to a byte-stream keyboard source and a byte-stream display sink with valid/ready handshakes. Reproduces the register semantics the Woz monitor polls: key-available flag, display-busy flag.

---
 rtl/apple1_pkg.sv | 27 ++
 rtl/apple1_pia.sv | 125 ++++++++++++
 tb/tb_apple1_pia.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apple1_pkg.sv
// ============================================================================
// Module      : apple1_pkg
// Description : Shared constants and helpers for the Apple I PIA emulation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apple1_pkg;

  localparam logic [15:0] APPLE1_PIA_BASE = 16'hD010;

  localparam logic [1:0] PIA_KBD   = 2'd0;
  localparam logic [1:0] PIA_KBDCR = 2'd1;
  localparam logic [1:0] PIA_DSP   = 2'd2;
  localparam logic [1:0] PIA_DSPCR = 2'd3;

  // Only the full 8-bit codes 'a'..'z' fold; everything else passes bits [6:0].
  function automatic logic [6:0] to_upper(input logic [7:0] c);
    logic [6:0] r;
    r = c[6:0];
    if (c >= 8'h61 && c <= 8'h7A) r[5] = 1'b0;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apple1_pia.sv
// ============================================================================
// Module      : apple1_pia
// Description : 6821-style keyboard/display register responder for the Apple I.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apple1_pia
  import apple1_pkg::*;
#(
  parameter logic [15:0] BASE      = APPLE1_PIA_BASE,
  parameter int          UPPERCASE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] ab,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [6:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready
);

  logic [7:0] rdata_q, rdata_d;
  logic [6:0] kbd_key_q, kbd_key_d;
  logic       kbd_flag_q, kbd_flag_d;
  logic [6:0] kbdcr_q, kbdcr_d;
  logic [6:0] dsp_reg_q, dsp_reg_d;
  logic       dsp_busy_q, dsp_busy_d;
  logic [6:0] dspcr_q, dspcr_d;

  logic       w_hit;
  logic [1:0] w_off;
  logic       w_rd;
  logic       w_wr;
  logic       w_kbd_accept;
  logic [6:0] w_kbd_code;
  logic       w_unused_wdata7;

  assign w_hit  = (ab[15:2] == BASE[15:2]);
  assign w_off  = ab[1:0];
  assign w_rd   = enable & ~we & w_hit;
  assign w_wr   = enable &  we & w_hit;

  // Bit 7 of every writable register is either constant or status-driven.
  assign w_unused_wdata7 = wdata[7];

  assign kbd_ready    = ~kbd_flag_q;
  assign w_kbd_accept = kbd_valid & ~kbd_flag_q;
  assign w_kbd_code   = (UPPERCASE != 0) ? to_upper(kbd_data) : kbd_data[6:0];

  assign dsp_valid = dsp_busy_q;
  assign dsp_data  = dsp_reg_q;
  assign rdata     = rdata_q;

  always_comb begin
    rdata_d = 8'h00;
    if (w_hit) begin
      case (w_off)
        PIA_KBD:   rdata_d = {1'b1, kbd_key_q};
        PIA_KBDCR: rdata_d = {kbd_flag_q, kbdcr_q};
        PIA_DSP:   rdata_d = {dsp_busy_q, dsp_reg_q};
        default:   rdata_d = {1'b0, dspcr_q};
      endcase
    end
  end

  // Accept needs flag==0 and a KBD read only matters with flag==1, so they never collide.
  always_comb begin
    kbd_key_d  = kbd_key_q;
    kbd_flag_d = kbd_flag_q;
    if (w_rd && w_off == PIA_KBD) kbd_flag_d = 1'b0;
    if (w_kbd_accept) begin
      kbd_key_d  = w_kbd_code;
      kbd_flag_d = 1'b1;
    end
  end

  // A write in the completion cycle sees busy=1 and is therefore dropped.
  always_comb begin
    dsp_reg_d  = dsp_reg_q;
    dsp_busy_d = dsp_busy_q;
    if (dsp_busy_q && dsp_ready) begin
      dsp_busy_d = 1'b0;
    end else if (w_wr && w_off == PIA_DSP && !dsp_busy_q) begin
      dsp_reg_d  = wdata[6:0];
      dsp_busy_d = 1'b1;
    end
  end

  always_comb begin
    kbdcr_d = kbdcr_q;
    dspcr_d = dspcr_q;
    if (w_wr && w_off == PIA_KBDCR) kbdcr_d = wdata[6:0];
    if (w_wr && w_off == PIA_DSPCR) dspcr_d = wdata[6:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= 8'h00;
      kbd_key_q  <= 7'h00;
      kbd_flag_q <= 1'b0;
      kbdcr_q    <= 7'h00;
      dsp_reg_q  <= 7'h00;
      dsp_busy_q <= 1'b0;
      dspcr_q    <= 7'h00;
    end else begin
      rdata_q    <= rdata_d;
      kbd_key_q  <= kbd_key_d;
      kbd_flag_q <= kbd_flag_d;
      kbdcr_q    <= kbdcr_d;
      dsp_reg_q  <= dsp_reg_d;
      dsp_busy_q <= dsp_busy_d;
      dspcr_q    <= dspcr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apple1_pia.sv
// ============================================================================
// Module      : tb_apple1_pia
// Description : Directed and randomized self-checking bench for apple1_pia.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apple1_pia;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] ab;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  rdata;
  logic [7:0]  kbd_data;
  logic        kbd_valid;
  logic        kbd_ready;
  logic [6:0]  dsp_data;
  logic        dsp_valid;
  logic        dsp_ready;

  int checks;
  int failures;

  // Reference state for the randomized run.
  logic [6:0] m_key, m_kbdcr, m_dsp, m_dspcr;
  logic       m_flag, m_busy;
  logic [7:0] m_rdata;

  apple1_pia dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ab        (ab),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .kbd_ready (kbd_ready),
    .dsp_data  (dsp_data),
    .dsp_valid (dsp_valid),
    .dsp_ready (dsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One CPU access; on return (next negedge) rdata shows the value read.
  task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1;
    ab     = a;
    we     = w;
    wdata  = d;
    @(negedge clk);
    enable = 1'b0;
    we     = 1'b0;
  endtask

  task automatic push_key(input logic [7:0] k);
    @(negedge clk);
    kbd_data  = k;
    kbd_valid = 1'b1;
    @(negedge clk);
    kbd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0; we = 1'b0; ab = 16'h0000; wdata = 8'h00;
    kbd_valid = 1'b0; kbd_data = 8'h00; dsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    push_key(8'h55);
    bus(16'hD012, 1'b1, 8'h33);
    bus(16'hD011, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'h80) begin
      failures++;
      $display("FAIL reset_pre_kbdcr: got %h want 80", rdata);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rdata !== 8'h00 || kbd_ready !== 1'b1 || dsp_valid !== 1'b0 || dsp_data !== 7'h00) begin
      failures++;
      $display("FAIL reset_async: rdata=%h kbd_ready=%b dsp_valid=%b dsp_data=%h want 00/1/0/00",
               rdata, kbd_ready, dsp_valid, dsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bus(16'hD011, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_kbdcr: got %h want 00", rdata);
    end
  endtask

  task automatic test_key();
    push_key(8'h61);
    bus(16'hD011, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'h80 || kbd_ready !== 1'b0) begin
      failures++;
      $display("FAIL key_flag: rdata=%h kbd_ready=%b want 80/0", rdata, kbd_ready);
    end
    bus(16'hD010, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'hC1) begin
      failures++;
      $display("FAIL key_read: got %h want C1", rdata);
    end
    bus(16'hD011, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'h00 || kbd_ready !== 1'b1) begin
      failures++;
      $display("FAIL key_cleared: rdata=%h kbd_ready=%b want 00/1", rdata, kbd_ready);
    end
  endtask

  task automatic test_backpressure();
    push_key(8'h41);
    @(negedge clk);
    kbd_data  = 8'h42;
    kbd_valid = 1'b1;
    bus(16'hD010, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'hC1) begin
      failures++;
      $display("FAIL bp_first: got %h want C1", rdata);
    end
    @(negedge clk);
    kbd_valid = 1'b0;
    checks++;
    if (kbd_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept: kbd_ready=%b want 0", kbd_ready);
    end
    bus(16'hD010, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'hC2) begin
      failures++;
      $display("FAIL bp_second: got %h want C2", rdata);
    end
  endtask

  task automatic test_display();
    bus(16'hD012, 1'b1, 8'h8D);
    checks++;
    if (dsp_valid !== 1'b1 || dsp_data !== 7'h0D) begin
      failures++;
      $display("FAIL dsp_write: valid=%b data=%h want 1/0D", dsp_valid, dsp_data);
    end
    bus(16'hD012, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'h8D) begin
      failures++;
      $display("FAIL dsp_read_busy: got %h want 8D", rdata);
    end
    bus(16'hD012, 1'b1, 8'h41);
    checks++;
    if (dsp_data !== 7'h0D || dsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL dsp_drop: data=%h valid=%b want 0D/1", dsp_data, dsp_valid);
    end
    @(negedge clk);
    dsp_ready = 1'b1;
    @(negedge clk);
    dsp_ready = 1'b0;
    bus(16'hD012, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'h0D || dsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL dsp_done: rdata=%h valid=%b want 0D/0", rdata, dsp_valid);
    end
    // Completion and a new write on the same edge: write must be lost.
    bus(16'hD012, 1'b1, 8'h11);
    @(negedge clk);
    dsp_ready = 1'b1;
    enable = 1'b1; we = 1'b1; ab = 16'hD012; wdata = 8'h22;
    @(negedge clk);
    dsp_ready = 1'b0; enable = 1'b0; we = 1'b0;
    checks++;
    if (dsp_valid !== 1'b0 || dsp_data !== 7'h11) begin
      failures++;
      $display("FAIL dsp_collide: valid=%b data=%h want 0/11", dsp_valid, dsp_data);
    end
  endtask

  task automatic test_ctrl_decode();
    bus(16'hD011, 1'b1, 8'hA7);
    bus(16'hD013, 1'b1, 8'hA7);
    bus(16'hD011, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'h27) begin
      failures++;
      $display("FAIL kbdcr_rb: got %h want 27", rdata);
    end
    bus(16'hD013, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'h27) begin
      failures++;
      $display("FAIL dspcr_rb: got %h want 27", rdata);
    end
    bus(16'hD014, 1'b1, 8'h5A);
    checks++;
    if (rdata !== 8'h00 || dsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL miss: rdata=%h dsp_valid=%b want 00/0", rdata, dsp_valid);
    end
    bus(16'hD00F, 1'b1, 8'h12);
    bus(16'hD013, 1'b0, 8'h00);
    checks++;
    if (rdata !== 8'h27) begin
      failures++;
      $display("FAIL miss_nochange: got %h want 27", rdata);
    end
    // enable low: neither a write nor a read may have side effects.
    push_key(8'h7A);
    @(negedge clk);
    ab = 16'hD012; we = 1'b1; wdata = 8'h44; enable = 1'b0;
    @(negedge clk);
    ab = 16'hD010; we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dsp_valid !== 1'b0 || kbd_ready !== 1'b0 || rdata !== 8'hDA) begin
      failures++;
      $display("FAIL enable_low: dsp_valid=%b kbd_ready=%b rdata=%h want 0/0/DA",
               dsp_valid, kbd_ready, rdata);
    end
    bus(16'hD010, 1'b0, 8'h00);
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (a < 16'hD010 || a > 16'hD013) return 8'h00;
    case (a - 16'hD010)
      16'd0:   return 8'h80 + {1'b0, m_key};
      16'd1:   return (m_flag ? 8'h80 : 8'h00) + {1'b0, m_kbdcr};
      16'd2:   return (m_busy ? 8'h80 : 8'h00) + {1'b0, m_dsp};
      default: return {1'b0, m_dspcr};
    endcase
  endfunction

  task automatic test_random();
    logic [7:0]  c;
    logic        hit;
    logic [15:0] off;
    logic        n_flag, n_busy;
    apply_reset();
    m_key = 0; m_kbdcr = 0; m_dsp = 0; m_dspcr = 0; m_flag = 0; m_busy = 0; m_rdata = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      checks++;
      if (rdata !== m_rdata || kbd_ready !== !m_flag || dsp_valid !== m_busy || dsp_data !== m_dsp) begin
        failures++;
        $display("FAIL rand[%0d]: rdata=%h/%h ready=%b/%b valid=%b/%b data=%h/%h (got/want)",
                 i, rdata, m_rdata, kbd_ready, !m_flag, dsp_valid, m_busy, dsp_data, m_dsp);
      end
      enable    = ($urandom_range(0, 3) != 0);
      we        = $urandom_range(0, 1) == 1;
      wdata     = 8'($urandom);
      kbd_valid = ($urandom_range(0, 2) == 0);
      kbd_data  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h61, 8'h7A)) : 8'($urandom);
      dsp_ready = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: ab = 16'hD010;
        1: ab = 16'hD011;
        2: ab = 16'hD012;
        3: ab = 16'hD013;
        4: ab = 16'hD014;
        5: ab = 16'hD00F;
        6: ab = 16'($urandom);
        default: ab = 16'hD012;
      endcase
      m_rdata = model_read(ab);
      hit = (ab >= 16'hD010 && ab <= 16'hD013);
      off = ab - 16'hD010;
      n_flag = m_flag;
      n_busy = m_busy;
      if (enable && !we && hit && off == 0) n_flag = 1'b0;
      if (kbd_valid && !m_flag) begin
        c = kbd_data;
        if (c >= "a" && c <= "z") c = c - 8'd32;
        m_key  = c[6:0];
        n_flag = 1'b1;
      end
      if (m_busy && dsp_ready) n_busy = 1'b0;
      else if (enable && we && hit && off == 2 && !m_busy) begin
        m_dsp  = wdata[6:0];
        n_busy = 1'b1;
      end
      if (enable && we && hit && off == 1) m_kbdcr = wdata[6:0];
      if (enable && we && hit && off == 3) m_dspcr = wdata[6:0];
      m_flag = n_flag;
      m_busy = n_busy;
    end
    @(negedge clk);
    enable = 1'b0; we = 1'b0; kbd_valid = 1'b0; dsp_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    enable = 1'b0; we = 1'b0; ab = 16'h0000; wdata = 8'h00;
    kbd_valid = 1'b0; kbd_data = 8'h00; dsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_key();
    test_backpressure();
    apply_reset();
    test_display();
    apply_reset();
    test_ctrl_decode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
